// File: rtl/scic_switch_input.sv
// Switch-bank input responder: two-flop synchroniser, debounce, and a stable value
// with sticky changed/change_mask/overrun flags that a CPU read clears.
module scic_switch_input #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] switches_in,
  input  logic             rd_strobe,
  output logic [WIDTH-1:0] rd_data,
  output logic             changed,
  output logic [WIDTH-1:0] change_mask,
  output logic             overrun
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_cand;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_stable;
  logic             r_changed;
  logic [WIDTH-1:0] r_mask;
  logic             r_overrun;

  logic             w_cand_hold;
  logic             w_at_max;
  logic             w_accept;
  logic [WIDTH-1:0] w_diff;

  assign w_cand_hold = (r_sync2 == r_cand);
  assign w_at_max    = (r_count >= CNT_MAX);
  assign w_accept    = w_cand_hold && w_at_max && (r_cand != r_stable);
  assign w_diff      = r_cand ^ r_stable;

  // Two-flop chain; switches_in reaches nothing else.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= switches_in;
      r_sync2 <= r_sync1;
    end
  end

  // Any difference between the synchronised sample and the candidate restarts the count.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cand   <= '0;
      r_count  <= '0;
      r_stable <= '0;
    end else if (!w_cand_hold) begin
      r_cand  <= r_sync2;
      r_count <= '0;
    end else if (!w_at_max) begin
      r_count <= r_count + 1'b1;
    end else if (w_accept) begin
      r_stable <= r_cand;
    end
  end

  // A read on the same edge as an acceptance consumes the old state; the new event stays pending.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_changed <= 1'b0;
      r_mask    <= '0;
      r_overrun <= 1'b0;
    end else if (w_accept && rd_strobe) begin
      r_changed <= 1'b1;
      r_mask    <= w_diff;
      r_overrun <= 1'b0;
    end else if (w_accept) begin
      r_changed <= 1'b1;
      r_mask    <= r_mask | w_diff;
      r_overrun <= r_overrun | r_changed;
    end else if (rd_strobe) begin
      r_changed <= 1'b0;
      r_mask    <= '0;
      r_overrun <= 1'b0;
    end
  end

  assign rd_data     = r_stable;
  assign changed     = r_changed;
  assign change_mask = r_mask;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_scic_switch_input.sv
// Directed bench for scic_switch_input: latency, bounce rejection, sticky flags,
// same-edge read/accept and asynchronous reset.
module tb_scic_switch_input;

  logic       clock;
  logic       reset;
  logic [3:0] switches_in;
  logic       rd_strobe;
  logic [3:0] rd_data;
  logic       changed;
  logic [3:0] change_mask;
  logic       overrun;

  int n_cmp;
  int n_err;

  scic_switch_input #(.WIDTH(4), .DEBOUNCE_CYCLES(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .switches_in (switches_in),
    .rd_strobe   (rd_strobe),
    .rd_data     (rd_data),
    .changed     (changed),
    .change_mask (change_mask),
    .overrun     (overrun)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance n rising edges, then settle 5 ns past the last one.
  task automatic edges(input int n);
    repeat (n) @(posedge clock);
    #5;
  endtask

  task automatic do_read();
    rd_strobe = 1'b1;
    edges(1);
    rd_strobe = 1'b0;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] d, input logic c,
                         input logic [3:0] m, input logic o);
    chk({tag, ".rd_data"}, 32'(rd_data), 32'(d));
    chk({tag, ".changed"}, 32'(changed), 32'(c));
    chk({tag, ".mask"},    32'(change_mask), 32'(m));
    chk({tag, ".overrun"}, 32'(overrun), 32'(o));
  endtask

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    reset       = 1'b0;
    switches_in = 4'b0000;
    rd_strobe   = 1'b0;
    #5;
    chk_all("reset", 4'h0, 1'b0, 4'h0, 1'b0);

    // Clean step 0000 -> 0101: accepted on exactly the 7th edge.
    #22 reset = 1'b1;
    #13 switches_in = 4'b0101;
    for (int k = 1; k <= 6; k++) begin
      edges(1);
      chk("step.early_data", 32'(rd_data), 32'h0);
      chk("step.early_chg",  32'(changed), 32'h0);
    end
    edges(1);
    chk_all("step.edge7", 4'b0101, 1'b1, 4'b0101, 1'b0);
    do_read();
    chk_all("step.read", 4'b0101, 1'b0, 4'h0, 1'b0);

    switches_in = 4'b0000;
    edges(10);
    do_read();
    chk_all("to_zero", 4'b0000, 1'b0, 4'h0, 1'b0);

    // Bounce bit0 with 2-cycle dwell, then hold 1.
    switches_in = 4'b0001; edges(2);
    switches_in = 4'b0000; edges(2);
    switches_in = 4'b0001;
    edges(6);
    chk("bounce.edge6_data", 32'(rd_data), 32'h0);
    chk("bounce.edge6_chg",  32'(changed), 32'h0);
    edges(1);
    chk_all("bounce.edge7", 4'b0001, 1'b1, 4'b0001, 1'b0);
    do_read();

    // 3-sample glitch never reaches rd_data.
    switches_in = 4'b0011; edges(3);
    switches_in = 4'b0001; edges(12);
    chk_all("glitch", 4'b0001, 1'b0, 4'h0, 1'b0);
    do_read();
    chk("glitch.read_chg", 32'(changed), 32'h0);

    // Two unread events set overrun; one read clears all flags.
    switches_in = 4'b0000; edges(10);
    do_read();
    switches_in = 4'b0001; edges(10);
    chk_all("ovr.first", 4'b0001, 1'b1, 4'b0001, 1'b0);
    switches_in = 4'b0011; edges(10);
    chk_all("ovr.second", 4'b0011, 1'b1, 4'b0011, 1'b1);
    do_read();
    chk_all("ovr.read", 4'b0011, 1'b0, 4'h0, 1'b0);

    // Build changed=1/overrun=1, then read on the acceptance edge of 0111.
    switches_in = 4'b0001; edges(10);
    switches_in = 4'b0011; edges(10);
    chk_all("same.pre", 4'b0011, 1'b1, 4'b0010, 1'b1);
    switches_in = 4'b0111;
    edges(6);
    chk("same.edge6_data", 32'(rd_data), 32'h3);
    rd_strobe = 1'b1;
    edges(1);
    rd_strobe = 1'b0;
    chk_all("same.edge7", 4'b0111, 1'b1, 4'b0100, 1'b0);

    // Mid-debounce asynchronous reset with rd_data=0011.
    switches_in = 4'b0011; edges(10);
    do_read();
    chk_all("mid.pre", 4'b0011, 1'b0, 4'h0, 1'b0);
    switches_in = 4'b0111;
    edges(5);
    chk("mid.count", 32'(dut.r_count), 32'd2);
    reset = 1'b0;
    #2;
    chk_all("mid.async", 4'h0, 1'b0, 4'h0, 1'b0);
    switches_in = 4'b0011;
    #6 reset = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      edges(1);
      chk("mid.early_chg", 32'(changed), 32'h0);
    end
    edges(1);
    chk_all("mid.edge7", 4'b0011, 1'b1, 4'b0011, 1'b0);

    // Idle all-zero input after reset keeps everything at zero.
    reset = 1'b0;
    switches_in = 4'b0000;
    #8 reset = 1'b1;
    for (int k = 0; k < 20; k++) begin
      edges(1);
      chk("idle", 32'({rd_data, changed, change_mask, overrun}), 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/scic_switch_input.md
Name: scic_switch_input

Overview:
- Input-side responder for the SCIC switch port; the counterpart of whatever drives the `switches` pins.
- Synchronises and debounces the raw switch bank and holds a stable value for the CPU's IO read path.
- Flags new values with a sticky change/overrun handshake that a CPU read clears.
- Sits between the top-level `switches` pins and the SCIC IO-read mux, in the `clock` domain.

Parameters:
- WIDTH, 4: number of switch bits.
- DEBOUNCE_CYCLES, 4: consecutive stable synchronised samples required before acceptance; legal range 1..65535.

Ports:
- clock  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- switches_in  input  WIDTH  raw, asynchronous switch levels.
- rd_strobe  input  1  one-cycle CPU read acknowledge for the switch port.
- rd_data  output  WIDTH  debounced stable switch value.
- changed  output  1  sticky flag: stable value changed since last rd_strobe.
- change_mask  output  WIDTH  bits that toggled in stable value since last rd_strobe.
- overrun  output  1  sticky flag: a second change was accepted while changed=1 and unread.

Behaviour:
- Reset (reset=0, asynchronous):
  - sync1, sync2, candidate, rd_data, count, changed, change_mask and overrun all go to 0.
  - Any in-progress debounce is discarded.
- Synchroniser: two-flop chain, switches_in -> sync1 -> sync2. No combinational path from switches_in to any output.
- Debounce, evaluated each rising edge:
  - If sync2 != candidate: candidate <= sync2, count <= 0.
  - Else if count < DEBOUNCE_CYCLES-1: count++.
  - Else, if candidate != rd_data: accept event; rd_data <= candidate. count saturates at DEBOUNCE_CYCLES-1.
- Latency:
  - A clean input change is accepted on the (DEBOUNCE_CYCLES+3)-th rising edge, counting the first edge that samples the new level.
  - Default: 7 edges = 140 ns at a 20 ns period.
  - Any bounce restarts the count. Pulses shorter than DEBOUNCE_CYCLES synchronised samples never reach rd_data.
  - Return to the old value before acceptance produces no event.
- Event handling, with diff = candidate XOR old rd_data:
  - Event, no rd_strobe: changed <= 1; change_mask <= change_mask | diff; overrun <= overrun | changed.
  - rd_strobe, no event: changed <= 0, change_mask <= 0, overrun <= 0.
  - rd_strobe and event on the same edge: changed <= 1, change_mask <= diff, overrun <= 0. The read consumes the old state and the new event is pending.
  - rd_strobe while changed=0: no effect beyond clearing, which is harmless.
- rd_data is always the latest accepted value. A read never blocks acceptance.
- Post-reset: a nonzero switches_in present at reset release is reported as a normal event after the standard latency.
- Reset asserted mid-operation clears every flag and rd_data immediately, regardless of the clock.
- Width rules:
  - count is ceil(log2(DEBOUNCE_CYCLES)) bits, minimum 1.
  - DEBOUNCE_CYCLES=1 accepts on the first matching sample after candidate update; latency is 4 edges.

Test Plan:
- Reset, then switches_in=4'b0000 for 20 cycles -> rd_data=0, changed=0, change_mask=0, overrun=0 throughout.
- Release reset at 27 ns, then step switches_in 0000->0101 at 40 ns -> rd_data=0101, changed=1 and change_mask=0101 after exactly 7 rising edges; no earlier partial value.
- Bounce bit0 0->1->0->1 with 2-cycle dwell, then hold 1 -> single event only, with rd_data=0001 on the 7th edge after the final transition; a 3-cycle glitch 0001->0011->0001 -> no event, changed stays 0 after read.
- Accept 0001 (no read), then 0011 -> changed=1, change_mask=0011, overrun=1; one-cycle rd_strobe -> all three clear next edge, rd_data stays 0011.
- Assert rd_strobe on the same edge a new value 0111 is accepted, starting from changed=1 and overrun=1 -> changed=1, change_mask=0100, overrun=0.
- Drive reset=0 mid-debounce (count=2) with rd_data=0011 -> all outputs 0 asynchronously; after release with switches_in=0011 held -> event after 7 edges, change_mask=0011.
